// File: rtl/alu_ctrl_sequencer.sv
// ALU control sequencer: decodes one op per request handshake and issues
// ALU control beats, splitting shifts into steps of at most MAX_STEP bits.
module alu_ctrl_sequencer #(
  parameter int DW       = 32,
  parameter int MAX_STEP = 8,
  parameter int FN_W     = 6,
  localparam int AW      = $clog2(DW)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      x_alu,
  input  logic [FN_W-1:0] fn,
  input  logic [AW-1:0]   shamt,
  output logic            ctrl_valid,
  input  logic            ctrl_ready,
  output logic [3:0]      ctrl,
  output logic [AW-1:0]   ctrl_amt,
  output logic            ctrl_last,
  output logic            ctrl_err
);

  localparam logic [AW-1:0] STEP = AW'(MAX_STEP);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_d;
  logic [3:0]    ctrl_q, ctrl_d;
  logic [AW-1:0] amt_q, amt_d;
  logic [AW-1:0] rem_q, rem_d;
  logic          last_q, last_d;
  logic          err_q, err_d;

  logic [3:0]    dec_code;
  logic          dec_err;
  logic          dec_shift;
  logic          accept;
  logic          consume;
  logic [AW-1:0] src_rem;

  always_comb begin
    dec_code  = 4'b0000;
    dec_err   = 1'b0;
    dec_shift = 1'b0;
    case (x_alu)
      3'b000: dec_code = 4'b0111;
      3'b010: dec_code = 4'b0001;
      3'b011: dec_code = 4'b0010;
      3'b001: begin
        case (fn)
          FN_W'(1):  dec_code = 4'b0001;
          FN_W'(2):  dec_code = 4'b0010;
          FN_W'(3):  dec_code = 4'b0011;
          FN_W'(4):  dec_code = 4'b0100;
          FN_W'(5):  begin
            dec_code  = 4'b1101;
            dec_shift = 1'b1;
          end
          FN_W'(6):  begin
            dec_code  = 4'b1110;
            dec_shift = 1'b1;
          end
          FN_W'(7):  dec_code = 4'b0101;
          FN_W'(8):  dec_code = 4'b0110;
          FN_W'(9):  dec_code = 4'b1111;
          FN_W'(10): dec_code = 4'b0111;
          FN_W'(11): dec_code = 4'b0000;
          default:   dec_err  = 1'b1;
        endcase
      end
      default: dec_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ctrl_q  <= 4'b0000;
      amt_q   <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      amt_q   <= amt_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = BUSY;
      BUSY: if (consume && last_q && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctrl_valid = (state_q == BUSY);
    req_ready  = !rst &&
                 ((state_q == IDLE) ||
                  (ctrl_valid && last_q && ctrl_ready));
    accept     = req_valid && req_ready;
    consume    = ctrl_valid && ctrl_ready;
  end

  // rem_q counts the distance still owed, including the beat on display
  always_comb begin
    ctrl_d  = ctrl_q;
    err_d   = err_q;
    amt_d   = amt_q;
    last_d  = last_q;
    rem_d   = rem_q;
    src_rem = rem_q - amt_q;
    if (accept) begin
      src_rem = (dec_shift && !dec_err) ? shamt : '0;
      ctrl_d  = dec_code;
      err_d   = dec_err;
    end
    if (accept || (consume && !last_q)) begin
      rem_d  = src_rem;
      amt_d  = (src_rem > STEP) ? STEP : src_rem;
      last_d = (src_rem <= STEP);
    end else if (consume) begin
      rem_d  = src_rem;
    end
  end

  assign ctrl      = ctrl_q;
  assign ctrl_amt  = amt_q;
  assign ctrl_last = last_q;
  assign ctrl_err  = err_q;

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Bench for alu_ctrl_sequencer: decode table, shift splitting, stalls,
// reset behaviour and random traffic against a beat-queue model.
module tb_alu_ctrl_sequencer;

  localparam int MS = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] x_alu;
  logic [5:0] fn;
  logic [4:0] shamt;
  logic       ctrl_valid;
  logic       ctrl_ready;
  logic [3:0] ctrl;
  logic [4:0] ctrl_amt;
  logic       ctrl_last;
  logic       ctrl_err;

  alu_ctrl_sequencer #(.DW(32), .MAX_STEP(MS), .FN_W(6)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .x_alu(x_alu), .fn(fn), .shamt(shamt),
    .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
    .ctrl(ctrl), .ctrl_amt(ctrl_amt),
    .ctrl_last(ctrl_last), .ctrl_err(ctrl_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] code;
    logic [4:0] amt;
    logic       last;
    logic       err;
  } beat_t;

  typedef struct {
    logic [2:0] x;
    logic [5:0] f;
    logic [4:0] s;
    logic [3:0] code;
    bit         err;
    bit         sh;
  } vec_t;

  localparam logic [3:0] FN_TBL [1:11] = '{
    4'h1, 4'h2, 4'h3, 4'h4, 4'hD, 4'hE,
    4'h5, 4'h6, 4'hF, 4'h7, 4'h0
  };

  beat_t q[$];
  int    vec_cnt = 0;
  int    miss    = 0;
  int    consumed = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void ref_decode(input logic [2:0] x,
                                     input logic [5:0] f,
                                     output logic [3:0] c,
                                     output bit err, output bit sh);
    c = 4'h0; err = 1'b0; sh = 1'b0;
    if (x == 3'd0) c = 4'h7;
    else if (x == 3'd2) c = 4'h1;
    else if (x == 3'd3) c = 4'h2;
    else if (x == 3'd1 && f >= 1 && f <= 11) begin
      c  = FN_TBL[int'(f)];
      sh = (f == 6'd5 || f == 6'd6);
    end else err = 1'b1;
  endfunction

  function automatic void push_op(logic [3:0] c, bit err, bit sh, int s);
    int rem;
    int a;
    if (err) q.push_back(beat_t'{4'h0, 5'd0, 1'b1, 1'b1});
    else if (!sh) q.push_back(beat_t'{c, 5'd0, 1'b1, 1'b0});
    else begin
      rem = s;
      do begin
        a = (rem > MS) ? MS : rem;
        rem -= a;
        q.push_back(beat_t'{c, 5'(a), rem == 0, 1'b0});
      end while (rem > 0);
    end
  endfunction

  task automatic cycle(input bit rv, input logic [2:0] x,
                       input logic [5:0] f, input logic [4:0] s,
                       input bit cr, input logic [3:0] c,
                       input bit err, input bit sh, output bit acc);
    bit exp_rr;
    @(negedge clk);
    req_valid = rv; x_alu = x; fn = f; shamt = s; ctrl_ready = cr;
    #1;
    chk("ctrl_valid", ctrl_valid, q.size() > 0);
    exp_rr = (q.size() == 0) || (q[0].last && cr);
    chk("req_ready", req_ready, exp_rr);
    if (ctrl_valid && q.size() > 0) begin
      chk("beat", {ctrl, ctrl_amt, ctrl_last, ctrl_err}, q[0]);
      if (cr) begin
        void'(q.pop_front());
        consumed++;
      end
    end
    acc = rv && req_ready;
    if (acc) push_op(c, err, sh, int'(s));
  endtask

  task automatic send(input logic [2:0] x, input logic [5:0] f,
                      input logic [4:0] s, input bit cr);
    logic [3:0] c;
    bit err, sh, acc;
    int n = 0;
    ref_decode(x, f, c, err, sh);
    do begin
      cycle(1'b1, x, f, s, cr, c, err, sh, acc);
      n++;
    end while (!acc && n < 40);
    if (!acc) begin
      miss++;
      $display("FAIL accept_timeout: got no accept required accept");
    end
  endtask

  task automatic idle(input int n, input bit cr);
    bit acc;
    for (int i = 0; i < n; i++)
      cycle(1'b0, 3'd0, 6'd0, 5'd0, cr, 4'h0, 1'b0, 1'b0, acc);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      idle(1, 1'b1);
      n++;
    end
    if (q.size() > 0) begin
      miss++;
      $display("FAIL drain_timeout: got %0d beats left required 0",
               q.size());
    end
    idle(1, 1'b1);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1; req_valid = 1'b1; ctrl_ready = 1'b1;
      #1;
      if (i > 0)
        chk("rst_outs", {ctrl_valid, ctrl, ctrl_amt, ctrl_last, ctrl_err}, 0);
      chk("rst_req_ready", req_ready, 0);
    end
    q.delete();
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    #1;
    chk("post_rst_outs",
        {ctrl_valid, ctrl, ctrl_amt, ctrl_last, ctrl_err}, 0);
    chk("post_rst_ready", req_ready, 1);
  endtask

  vec_t vt[18];

  initial begin
    bit acc, have, rv, err, sh;
    logic [2:0] rx;
    logic [5:0] rf;
    logic [4:0] rs;
    logic [3:0] rc;

    rst = 1'b1; req_valid = 1'b0; ctrl_ready = 1'b0;
    x_alu = 3'd0; fn = 6'd0; shamt = 5'd0;

    do_reset(2);
    idle(1, 1'b0);

    for (int i = 0; i < 11; i++)
      vt[i] = '{3'd1, 6'(i + 1), 5'(i + 3), FN_TBL[i + 1], 1'b0,
                (i == 4 || i == 5)};
    vt[11] = '{3'd0, 6'd0,  5'd9,  4'h7, 1'b0, 1'b0};
    vt[12] = '{3'd2, 6'd5,  5'd9,  4'h1, 1'b0, 1'b0};
    vt[13] = '{3'd3, 6'd6,  5'd9,  4'h2, 1'b0, 1'b0};
    vt[14] = '{3'd5, 6'd1,  5'd4,  4'h0, 1'b1, 1'b0};
    vt[15] = '{3'd1, 6'd0,  5'd4,  4'h0, 1'b1, 1'b0};
    vt[16] = '{3'd1, 6'd63, 5'd4,  4'h0, 1'b1, 1'b0};
    vt[17] = '{3'd1, 6'd4,  5'd4,  4'h4, 1'b0, 1'b0};

    for (int i = 0; i < 18; i++) begin
      cycle(1'b1, vt[i].x, vt[i].f, vt[i].s, 1'b1,
            vt[i].code, vt[i].err, vt[i].sh, acc);
      chk("b2b_accept", acc, 1);
    end
    drain();

    consumed = 0;
    send(3'd1, 6'd5, 5'd19, 1'b1);
    idle(1, 1'b1); idle(1, 1'b0); idle(1, 1'b1);
    idle(1, 1'b0); idle(1, 1'b1);
    chk("shift19_beats", consumed, 3);
    idle(1, 1'b1);

    consumed = 0; send(3'd1, 6'd5, 5'd0, 1'b1);  drain();
    chk("shift0_beats", consumed, 1);
    consumed = 0; send(3'd1, 6'd6, 5'd8, 1'b1);  drain();
    chk("shift8_beats", consumed, 1);
    consumed = 0; send(3'd1, 6'd5, 5'd31, 1'b1); drain();
    chk("shift31_beats", consumed, 4);

    send(3'd1, 6'd6, 5'd30, 1'b1);
    idle(2, 1'b1);
    do_reset(1);
    idle(3, 1'b1);
    consumed = 0; send(3'd1, 6'd1, 5'd30, 1'b1); drain();
    chk("after_rst_beats", consumed, 1);

    have = 1'b0;
    rx = 3'd0; rf = 6'd0; rs = 5'd0; rc = 4'h0; err = 1'b0; sh = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!have) begin
        rx = ($urandom_range(0, 9) < 6) ? 3'd1 : 3'($urandom_range(0, 7));
        rf = ($urandom_range(0, 15) == 0) ? 6'd63
                                          : 6'($urandom_range(0, 13));
        rs = 5'($urandom_range(0, 31));
        ref_decode(rx, rf, rc, err, sh);
        have = 1'b1;
      end
      rv = ($urandom_range(0, 3) != 0);
      cycle(rv, rx, rf, rs, ($urandom_range(0, 3) != 0), rc, err, sh, acc);
      if (acc) have = 1'b0;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss);
    $finish;
  end

endmodule
